cla_seq_adder: RTL and testbench

Multi-word sequenced adder that performs an (N_BIT × N_WORDS)-bit addition by time-multiplexing a single `cla_adder_8bits` instance, one word per cycle. The carry is registered between words. Operands arrive on a valid/ready input handshake and the result leaves on a valid/ready output handshake. It sits between the operand-issuing control logic and any consumer that needs wide sums without paying for a wide carry-lookahead adder.

---
 rtl/cla_seq_adder.sv | 188 ++++++++++++++++++
 tb/tb_cla_seq_adder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cla_seq_adder.sv
// ---------------------------------------------------------------------------
// cla_seq_adder
//   Wide (N_BIT*N_WORDS-bit) adder built from a single N_BIT carry-lookahead
//   adder. It processes one word per cycle, least significant word first,
//   and registers the carry between words.
//
// Optional feature: define CLA_SEQ_SUB_EN to add the op_sub port, which
// selects subtraction (a - b mod 2^W).
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   in_valid/ready   operand handshake (a, b, cin, op_sub)
//   out_valid/ready  result handshake (result, cout)
//   busy             high while an operation is in RUN or DONE
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. A producer holds its payload stable while valid is high and ready
// is low. in_ready is high only in IDLE. out_valid is high only in DONE, and
// result/cout stay stable while it is high.
// ---------------------------------------------------------------------------
module cla_seq_adder #(
  parameter int N_BIT   = 8,
  parameter int N_WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_BIT*N_WORDS-1:0] a,
  input  logic [N_BIT*N_WORDS-1:0] b,
  input  logic                     cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic                     op_sub,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_BIT*N_WORDS-1:0] result,
  output logic                     cout,
  output logic                     busy
);

  localparam int W  = N_BIT * N_WORDS;
  localparam int KW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N_WORDS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  result_q, result_d;
  logic          carry_q, carry_d;
  logic          sub_q, sub_d;

  logic [N_BIT-1:0] add_a, add_b, add_sum;
  logic             add_cout;

  // The adder sees only latched operands and the carry register, so there is
  // no combinational path from the input ports to any output.
  always_comb begin
    add_a = a_q[k_q*N_BIT +: N_BIT];
    add_b = b_q[k_q*N_BIT +: N_BIT] ^ {N_BIT{sub_q}};
  end

  cla_adder_8bits #(.N_BIT(N_BIT)) u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    carry_d  = carry_q;
    sub_d    = sub_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          k_d      = '0;
          result_d = '0;
          state_d  = RUN;
`ifdef CLA_SEQ_SUB_EN
          // Two's complement subtract: invert b and inject a carry of 1.
          sub_d    = op_sub;
          carry_d  = op_sub ? 1'b1 : cin;
`else
          sub_d    = 1'b0;
          carry_d  = cin;
`endif
        end
      end
      RUN: begin
        result_d[k_q*N_BIT +: N_BIT] = add_sum;
        carry_d = add_cout;
        if (k_q == K_LAST) begin
          state_d = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      sub_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      sub_q    <= sub_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;
  assign cout      = carry_q;

endmodule

// ---------------------------------------------------------------------------
// cla_adder_8bits
//   Combinational N_BIT carry-lookahead adder. Each carry is the flat sum of
//   products of generate/propagate terms, not a ripple chain.
//   a, b, cin -> sum, cout
// ---------------------------------------------------------------------------
module cla_adder_8bits #(
  parameter int N_BIT = 8
) (
  input  logic [N_BIT-1:0] a,
  input  logic [N_BIT-1:0] b,
  input  logic             cin,
  output logic [N_BIT-1:0] sum,
  output logic             cout
);

  logic [N_BIT-1:0] g, p;
  logic [N_BIT:0]   c;
  logic             t;

  always_comb begin
    g = a & b;
    p = a ^ b;
    c = '0;
    t = 1'b0;
    c[0] = cin;
    for (int i = 0; i < N_BIT; i++) begin
      // c[i+1] = g[i] | p[i]g[i-1] | p[i]p[i-1]g[i-2] | ... | p[i..0]cin
      c[i+1] = g[i];
      t = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (t & g[j]);
        t = t & p[j];
      end
      c[i+1] = c[i+1] | (t & cin);
    end
    sum  = p ^ c[N_BIT-1:0];
    cout = c[N_BIT];
  end

endmodule

// File: tb/tb_cla_seq_adder.sv
// ---------------------------------------------------------------------------
// tb_cla_seq_adder
//   Self-checking bench for cla_seq_adder (N_BIT=8, N_WORDS=4). It applies
//   directed vectors from a table, hand-written backpressure and reset
//   sequences, and random transactions. Expected sums come from plain
//   33-bit arithmetic.
// ---------------------------------------------------------------------------
module tb_cla_seq_adder;

  localparam int N_BIT   = 8;
  localparam int N_WORDS = 4;
  localparam int W       = N_BIT * N_WORDS;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         op_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         busy;

  cla_seq_adder #(.N_BIT(N_BIT), .N_WORDS(N_WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef CLA_SEQ_SUB_EN
    .op_sub    (op_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .busy      (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard: {cout, result}
  logic [W:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_result;
    logic         exp_cout;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: wide arithmetic straight from the add/subtract rules.
  function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                       input logic mcin, input logic msub);
    logic [W:0] s;
    if (msub) s = {1'b0, ma} + {1'b0, ~mb} + (W+1)'(1);
    else      s = {1'b0, ma} + {1'b0, mb} + (W+1)'(mcin);
    return s;
  endfunction

  task automatic check_reset_outputs(input string name);
    check({name, "_in_ready"},  64'(in_ready),  64'd1);
    check({name, "_out_valid"}, 64'(out_valid), 64'd0);
    check({name, "_busy"},      64'(busy),      64'd0);
    check({name, "_result"},    64'(result),    64'd0);
    check({name, "_cout"},      64'(cout),      64'd0);
  endtask

  // Driver + checker for one transaction. hold cycles of out_ready=0 in DONE;
  // when pulse is set, in_valid is pulsed with junk operands during the hold.
  task automatic run_txn(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tcin, input logic tsub, input int hold, input bit pulse);
    int lat;
    logic [W:0] exp;
    @(negedge clk);
    check({name, "_in_ready_idle"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    a = ta;
    b = tb;
    cin = tcin;
    op_sub = tsub;
    exp_q.push_back(model(ta, tb, tcin, tsub));
    @(posedge clk);
    @(negedge clk);
    // Input changes after the accept edge must have no effect.
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    cin = 1'($urandom_range(0, 1));
    op_sub = 1'($urandom_range(0, 1));
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (!busy || in_ready) begin
        check({name, "_run_busy"}, {62'd0, busy, in_ready}, 64'd2);
      end
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'(N_WORDS));
    exp = exp_q.pop_front();
    check({name, "_result"}, 64'(result), 64'(exp[W-1:0]));
    check({name, "_cout"},   64'(cout),   64'(exp[W]));
    for (int i = 0; i < hold; i++) begin
      if (pulse) begin
        in_valid = 1'(i % 2 == 0);
        a = $urandom;
        b = $urandom;
      end
      @(negedge clk);
      check({name, "_hold_state"}, {61'd0, out_valid, in_ready, busy}, 64'd5);
      check({name, "_hold_data"}, 64'({cout, result}), 64'(exp));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_back_idle"}, {61'd0, out_valid, in_ready, busy}, 64'd2);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    op_sub = 1'b0;
    out_ready = 1'b0;

    vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1};
    vecs[2] = '{32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0};
    vecs[3] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0};
    vecs[4] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
    vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven vectors: exp_q holds the model value, the table's own
    // expected value is checked against it to keep both honest.
    for (int i = 0; i < 6; i++) begin
      logic [W:0] m;
      m = model(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0);
      check($sformatf("vec%0d_table", i), 64'(m), 64'({vecs[i].exp_cout, vecs[i].exp_result}));
      run_txn($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, 0, 1'b0);
    end

    // Backpressure: 5 cycles in DONE with in_valid pulsed.
    run_txn("bp", 32'hA5A5A5A5, 32'h5A5A5A5B, 1'b0, 1'b0, 5, 1'b1);
    run_txn("bp_next", 32'h00001000, 32'h00002000, 1'b0, 1'b0, 0, 1'b0);

    // Reset mid-RUN at k=2.
    @(negedge clk);
    in_valid = 1'b1;
    a = 32'hFFFFFFFF;
    b = 32'h00000001;
    cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrun_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_txn("after_reset", 32'h00000003, 32'h00000004, 1'b0, 1'b0, 0, 1'b0);

`ifdef CLA_SEQ_SUB_EN
    run_txn("sub_borrow", 32'h00000005, 32'h00000007, 1'b0, 1'b1, 0, 1'b0);
    check("sub_borrow_res", 64'(result), 64'hFFFFFFFE);
    run_txn("sub_noborrow", 32'h00000007, 32'h00000005, 1'b1, 1'b1, 0, 1'b0);
    check("sub_noborrow_cout", 64'(cout), 64'd1);
`endif

    // Random transactions with random DONE hold times.
    for (int i = 0; i < 40; i++) begin
      logic rsub;
`ifdef CLA_SEQ_SUB_EN
      rsub = 1'($urandom_range(0, 1));
`else
      rsub = 1'b0;
`endif
      run_txn($sformatf("rnd%0d", i), $urandom, $urandom, 1'($urandom_range(0, 1)),
              rsub, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
